// File: rtl/nibble_unpacker_pkg.sv
// Shared types and sizing helpers for nibble_unpacker and its slice selector.
package unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int slice_count(input int word_w, input int slice_w);
        return word_w / slice_w;
    endfunction

    // A single-slice word still needs a 1-bit counter so the datapath stays uniform.
    function automatic int idx_width(input int word_w, input int slice_w);
        return (word_w / slice_w > 1) ? $clog2(word_w / slice_w) : 1;
    endfunction

endpackage

// File: rtl/nibble_unpacker_slice_mux.sv
// Combinational slice selector: zero latency. MSB-first by default, LSB-first when
// UNPACK_LSB_FIRST_EN is defined. No handshake of its own.
module slice_mux #(
    parameter int WORD_W  = 8,
    parameter int SLICE_W = 4,
    parameter int IDX_W   = 1
) (
    input  logic [WORD_W-1:0]  i_hold,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [SLICE_W-1:0] o_slice
);

`ifdef UNPACK_LSB_FIRST_EN
    assign o_slice = SLICE_W'(i_hold >> (int'(i_idx) * SLICE_W));
`else
    assign o_slice = SLICE_W'(i_hold >> (WORD_W - SLICE_W * (int'(i_idx) + 1)));
`endif

endmodule

// File: rtl/nibble_unpacker.sv
// Word-to-slice unpacker (slice order set by UNPACK_LSB_FIRST_EN); first slice one cycle after accept.
// Holds the slice under out_ready low; in_ready rises combinationally on the last-slice transfer.
import unpack_pkg::*;

module nibble_unpacker #(
    parameter int WORD_W  = 8,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_data,
    output logic               out_last
);

    localparam int SLICES = slice_count(WORD_W, SLICE_W);
    localparam int IDX_W  = idx_width(WORD_W, SLICE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_hold;
    logic [WORD_W-1:0]    w_hold_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [SLICE_W-1:0]   r_out_data;
    logic [SLICE_W-1:0]   w_slice;
    logic                 r_out_last;
    logic                 w_in_acc;
    logic                 w_out_xfer;

    assign out_valid  = (r_state == EMIT);
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign w_out_xfer = out_valid && out_ready;
    assign in_ready   = rst_n && ((r_state == IDLE) || (w_out_xfer && r_out_last));
    assign w_in_acc   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
        if (w_in_acc) begin
            w_state_nxt = EMIT;
            w_hold_nxt  = in_data;
            w_idx_nxt   = '0;
        end else if (w_out_xfer) begin
            if (r_out_last) begin
                w_state_nxt = IDLE;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Outputs are registered, so the slice is selected from next-cycle hold/idx.
    slice_mux #(
        .WORD_W  (WORD_W),
        .SLICE_W (SLICE_W),
        .IDX_W   (IDX_W)
    ) u_slice_mux (
        .i_hold  (w_hold_nxt),
        .i_idx   (w_idx_nxt),
        .o_slice (w_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_hold     <= w_hold_nxt;
            r_idx      <= w_idx_nxt;
            r_out_data <= w_slice;
            r_out_last <= (w_idx_nxt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_nibble_unpacker.sv
// Bench for nibble_unpacker: an 8-bit and a 16-bit instance against a slice-queue model.
module tb_nibble_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_iv, a_ir, a_ov, a_or, a_ol;
    logic [7:0] a_id;
    logic [3:0] a_od;

    logic        b_iv, b_ir, b_ov, b_or, b_ol;
    logic [15:0] b_id;
    logic [3:0]  b_od;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] IDLE_RDY = 7'b000_0001;

    nibble_unpacker #(.WORD_W(8), .SLICE_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_last(a_ol)
    );

    nibble_unpacker #(.WORD_W(16), .SLICE_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_last(b_ol)
    );

    // Slice k of word w in emission order, straight from the field layout.
    function automatic logic [3:0] exp_slice(input logic [15:0] w, input int ww, input int k);
        int nib;
`ifdef UNPACK_LSB_FIRST_EN
        nib = k;
`else
        nib = ww / 4 - 1 - k;
`endif
        return 4'((w / (16'd1 << (4 * nib))) % 16);
    endfunction

    // Observed {valid, data, last, in_ready}; data/last are don't-care while invalid.
    function automatic logic [6:0] obs8();
        return a_ov ? {a_ov, a_od, a_ol, a_ir} : {1'b0, 4'h0, 1'b0, a_ir};
    endfunction

    function automatic logic [6:0] obs16();
        return b_ov ? {b_ov, b_od, b_ol, b_ir} : {1'b0, 4'h0, 1'b0, b_ir};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_iv = 1'b1; a_id = 8'hFF; a_or = 1'b1;
        b_iv = 1'b1; b_id = 16'hFFFF; b_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({a_ov, a_od, a_ol, a_ir} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset8: got %b want %b", {a_ov, a_od, a_ol, a_ir}, 7'b0);
        end
        vectors++;
        if ({b_ov, b_od, b_ol, b_ir} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset16: got %b want %b", {b_ov, b_od, b_ol, b_ir}, 7'b0);
        end
        a_iv = 1'b0; b_iv = 1'b0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic();
        logic [6:0] e [4];
        e = '{IDLE_RDY,
              {1'b1, exp_slice(16'hA5, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'hA5, 8, 1), 1'b1, 1'b1},
              IDLE_RDY};
        for (int c = 0; c < 4; c++) begin
            a_iv = (c == 0); a_id = 8'hA5; a_or = 1'b1;
            #1;
            vectors++;
            if (obs8() !== e[c]) begin
                miscompares++;
                $display("FAIL basic c%0d: got %b want %b", c, obs8(), e[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e [6];
        e = '{IDLE_RDY,
              {1'b1, exp_slice(16'h12, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'h12, 8, 1), 1'b1, 1'b1},
              {1'b1, exp_slice(16'h34, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'h34, 8, 1), 1'b1, 1'b1},
              IDLE_RDY};
        for (int c = 0; c < 6; c++) begin
            a_iv = (c < 3); a_id = (c == 0) ? 8'h12 : 8'h34; a_or = 1'b1;
            #1;
            vectors++;
            if (obs8() !== e[c]) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: got %b want %b", c, obs8(), e[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] e [7];
        e = '{IDLE_RDY,
              {1'b1, exp_slice(16'hC3, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'hC3, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'hC3, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'hC3, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'hC3, 8, 1), 1'b1, 1'b1},
              IDLE_RDY};
        for (int c = 0; c < 7; c++) begin
            a_iv = (c < 4);
            a_id = (c == 0) ? 8'hC3 : 8'($urandom);
            a_or = !(c >= 1 && c <= 3);
            #1;
            vectors++;
            if (obs8() !== e[c]) begin
                miscompares++;
                $display("FAIL backpressure c%0d: got %b want %b", c, obs8(), e[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_word();
        logic [6:0] e [7];
        e = '{IDLE_RDY,
              {1'b1, exp_slice(16'hF0, 8, 0), 1'b0, 1'b0},
              7'b0,
              IDLE_RDY,
              {1'b1, exp_slice(16'h9E, 8, 0), 1'b0, 1'b0},
              {1'b1, exp_slice(16'h9E, 8, 1), 1'b1, 1'b1},
              IDLE_RDY};
        for (int c = 0; c < 7; c++) begin
            rst_n = (c != 2);
            a_iv  = (c == 0) || (c == 3);
            a_id  = (c == 0) ? 8'hF0 : 8'h9E;
            a_or  = 1'b1;
            #1;
            vectors++;
            if (c == 2) begin
                if ({a_ov, a_od, a_ol, a_ir} !== e[c]) begin
                    miscompares++;
                    $display("FAIL reset_mid c%0d: got %b want %b", c, {a_ov, a_od, a_ol, a_ir}, e[c]);
                end
            end else if (obs8() !== e[c]) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: got %b want %b", c, obs8(), e[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_wide_word();
        logic [6:0] e [6];
        e[0] = IDLE_RDY;
        for (int k = 0; k < 4; k++)
            e[k+1] = {1'b1, exp_slice(16'hBEEF, 16, k), (k == 3), (k == 3)};
        e[5] = IDLE_RDY;
        for (int c = 0; c < 6; c++) begin
            b_iv = (c == 0); b_id = 16'hBEEF; b_or = 1'b1;
            #1;
            vectors++;
            if (obs16() !== e[c]) begin
                miscompares++;
                $display("FAIL wide c%0d: got %b want %b", c, obs16(), e[c]);
            end
            next_cycle();
        end
    endtask

    // Random traffic: the model is the queue of slices still owed for the current word.
    task automatic test_random();
        logic [3:0] q [$];
        logic [6:0] exp;
        logic       eir;
        for (int c = 0; c < 400; c++) begin
            a_iv = ($urandom_range(0, 3) != 0);
            a_id = 8'($urandom);
            a_or = ($urandom_range(0, 3) != 0) || (c >= 390);
            if (c >= 390) a_iv = 1'b0;
            #1;
            eir = (q.size() == 0) || (a_or && q.size() == 1);
            exp = (q.size() > 0) ? {1'b1, q[0], (q.size() == 1), eir} : {6'b0, eir};
            vectors++;
            if (obs8() !== exp) begin
                miscompares++;
                $display("FAIL random c%0d: got %b want %b", c, obs8(), exp);
            end
            if (q.size() > 0 && a_or) void'(q.pop_front());
            if (a_iv && eir) begin
                for (int k = 0; k < 2; k++) q.push_back(exp_slice({8'h00, a_id}, 8, k));
            end
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_iv = 1'b0; a_id = '0; a_or = 1'b0;
        b_iv = 1'b0; b_id = '0; b_or = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_wide_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
